// File: rtl/ieeedrv_pkg.sv
// Shared types for the IEEE drive SD-card arbiter: FSM state encoding,
// host request record and index-width helper.
package ieeedrv_pkg;

   typedef logic [1:0] sd_state_t;

   localparam sd_state_t ST_IDLE  = 2'd0;
   localparam sd_state_t ST_ISSUE = 2'd1;
   localparam sd_state_t ST_XFER  = 2'd2;
   localparam sd_state_t ST_DONE  = 2'd3;

   typedef struct packed {
      logic [31:0] lba;
      logic [5:0]  blk_cnt;
      logic        rd;
      logic        wr;
   } sd_req_t;

   // Width of a requester index; a single requester still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ieeedrv_rr_pick.sv
// Combinational round-robin picker: the first set request bit found
// searching upward from last+1 (mod NREQ) wins.
module ieeedrv_rr_pick
   import ieeedrv_pkg::*;
#(
   parameter int NREQ = 2,
   parameter int IW   = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   last,
   output logic            valid,
   output logic [IW-1:0]   index
);

   int   best_s;
   int   dist_s;
   logic hit_s;

   // Rank every requester by its distance past last and keep the closest one.
   always_comb begin
      best_s = NREQ;
      dist_s = 0;
      hit_s  = 1'b0;
      index  = '0;
      for (int i = 0; i < NREQ; i++) begin
         dist_s = (i + NREQ - 1 - int'(last)) % NREQ;
         hit_s  = req[i] && (dist_s < best_s);
         index  = hit_s ? IW'(i) : index;
         best_s = hit_s ? dist_s : best_s;
      end
      valid = |req;
   end

endmodule

// File: rtl/ieeedrv_sd_arb.sv
// Arbitrates several block-device requesters onto one SD host port:
// round-robin grant, request/ack handshake with timeout, data/strobe muxing.
module ieeedrv_sd_arb
   import ieeedrv_pkg::*;
#(
   parameter int NREQ  = 2,
   parameter int TMO_W = 24
) (
   input  logic                clk_sys,
   input  logic                reset,
   input  logic [32*NREQ-1:0]  req_lba,
   input  logic [6*NREQ-1:0]   req_blk_cnt,
   input  logic [NREQ-1:0]     req_rd,
   input  logic [NREQ-1:0]     req_wr,
   input  logic [8*NREQ-1:0]   req_buff_din,
   output logic [NREQ-1:0]     req_ack,
   output logic [NREQ-1:0]     req_buff_wr,
   output logic [31:0]         sd_lba,
   output logic [5:0]          sd_blk_cnt,
   output logic                sd_rd,
   output logic                sd_wr,
   input  logic                sd_ack,
   input  logic                sd_buff_wr,
   output logic [7:0]          sd_buff_din,
   output logic [NREQ-1:0]     grant,
   output logic                busy
);

   localparam int IW = idx_w(NREQ);

   sd_state_t        state_r;
   logic [IW-1:0]    last_r;
   logic [IW-1:0]    idx_r;
   logic [TMO_W-1:0] tmo_r;
   logic [NREQ-1:0]  grant_r;
   sd_req_t          sd_r;

   logic             pick_valid_s;
   logic [IW-1:0]    pick_idx_s;
   logic [NREQ-1:0]  onehot_s;
   logic [31:0]      lba_a_s [NREQ];
   logic [5:0]       cnt_a_s [NREQ];
   logic [7:0]       din_a_s [NREQ];
   logic             active_s;
   logic             ack_win_s;

   ieeedrv_rr_pick #(
      .NREQ (NREQ),
      .IW   (IW)
   ) u_pick (
      .req   (req_rd | req_wr),
      .last  (last_r),
      .valid (pick_valid_s),
      .index (pick_idx_s)
   );

   // Unpack the flattened per-requester buses and decode the pick to one-hot.
   always_comb begin
      for (int i = 0; i < NREQ; i++) begin
         lba_a_s[i]  = req_lba[32*i +: 32];
         cnt_a_s[i]  = req_blk_cnt[6*i +: 6];
         din_a_s[i]  = req_buff_din[8*i +: 8];
         onehot_s[i] = (pick_idx_s == IW'(i));
      end
      // The granted requester must keep the bit for the direction being served.
      active_s = sd_r.rd ? req_rd[idx_r] : req_wr[idx_r];
   end

   // Arbitration FSM; a read wins over a write raised by the same requester.
   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_r <= ST_IDLE;
         last_r  <= IW'(NREQ - 1);
         idx_r   <= '0;
         tmo_r   <= '0;
         grant_r <= '0;
         sd_r    <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (pick_valid_s) begin
                  state_r <= ST_ISSUE;
                  idx_r   <= pick_idx_s;
                  grant_r <= onehot_s;
                  tmo_r   <= '0;
                  sd_r    <= '{lba:     lba_a_s[pick_idx_s],
                               blk_cnt: cnt_a_s[pick_idx_s],
                               rd:      req_rd[pick_idx_s],
                               wr:      ~req_rd[pick_idx_s]};
               end
            end
            ST_ISSUE: begin
               if (!active_s) begin
                  // Withdrawn before the host answered: no turn is consumed.
                  state_r <= ST_IDLE;
                  grant_r <= '0;
                  sd_r.rd <= 1'b0;
                  sd_r.wr <= 1'b0;
               end else if (sd_ack) begin
                  state_r <= ST_XFER;
                  sd_r.rd <= 1'b0;
                  sd_r.wr <= 1'b0;
               end else if (&tmo_r) begin
                  // A dead host still rotates the turn so others are not starved.
                  state_r <= ST_IDLE;
                  grant_r <= '0;
                  last_r  <= idx_r;
                  sd_r.rd <= 1'b0;
                  sd_r.wr <= 1'b0;
               end else begin
                  tmo_r <= tmo_r + TMO_W'(1);
               end
            end
            ST_XFER: begin
               if (!sd_ack) begin
                  state_r <= ST_DONE;
               end
            end
            ST_DONE: begin
               last_r  <= idx_r;
               grant_r <= '0;
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
               grant_r <= '0;
            end
         endcase
      end
   end

   // Combinational handshake, strobe and data routing toward the requesters.
   always_comb begin
      ack_win_s = (state_r == ST_ISSUE) || (state_r == ST_XFER);
      if (reset) begin
         req_ack     = '0;
         req_buff_wr = '0;
         sd_buff_din = 8'h00;
         busy        = 1'b0;
      end else begin
         req_ack     = (sd_ack && ack_win_s) ? grant_r : '0;
         req_buff_wr = sd_buff_wr ? req_ack : '0;
         sd_buff_din = (|grant_r) ? din_a_s[idx_r] : 8'h00;
         busy        = (state_r != ST_IDLE);
      end
   end

   assign grant      = grant_r;
   assign sd_lba     = sd_r.lba;
   assign sd_blk_cnt = sd_r.blk_cnt;
   assign sd_rd      = sd_r.rd;
   assign sd_wr      = sd_r.wr;

endmodule
